// File: rtl/imem_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// imem_dmem_arbiter
//
// Shares one single-port main memory between the instruction-fetch stage
// (128-bit line fills on an I-cache miss) and the data stage (word loads and
// stores). Data requests win by default because they are older in the
// pipeline. After STARVE_LIMIT consecutive data grants made while an
// instruction miss waits, the instruction side is served next.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   i_req, i_addr         instruction miss request and miss PC
//   o_i_line, o_i_valid   fetched line and its one-cycle valid pulse
//   o_pc_hold             PC-update stall to the fetch stage
//   d_req, d_we, d_addr,
//   d_wdata               data load/store request
//   o_d_rdata, o_d_valid  load word and one-cycle completion pulse
//   mem_en, mem_we,
//   mem_addr, mem_wdata   memory request, held until mem_ready
//   mem_rdata, mem_ready  memory read line and one-cycle completion
// ---------------------------------------------------------------------------
module imem_dmem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_req,
    input  logic [31:0]  i_addr,
    output logic [127:0] o_i_line,
    output logic         o_i_valid,
    output logic         o_pc_hold,
    input  logic         d_req,
    input  logic         d_we,
    input  logic [31:0]  d_addr,
    input  logic [31:0]  d_wdata,
    output logic [31:0]  o_d_rdata,
    output logic         o_d_valid,
    output logic         mem_en,
    output logic         mem_we,
    output logic [31:0]  mem_addr,
    output logic [31:0]  mem_wdata,
    input  logic [127:0] mem_rdata,
    input  logic         mem_ready
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_I_BUSY = 2'd1;
    localparam logic [1:0] ST_D_BUSY = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    localparam logic [3:0] STARVE_LIMIT_C = 4'(STARVE_LIMIT);

    logic [1:0]   state_q,      state_d;
    logic [3:0]   starve_cnt_q, starve_cnt_d;
    logic         mem_en_q,     mem_en_d;
    logic         mem_we_q,     mem_we_d;
    logic [31:0]  mem_addr_q,   mem_addr_d;
    logic [31:0]  mem_wdata_q,  mem_wdata_d;
    logic [127:0] i_line_q,     i_line_d;
    logic [31:0]  d_rdata_q,    d_rdata_d;
    logic         i_valid_q,    i_valid_d;
    logic         d_valid_q,    d_valid_d;

    logic         data_win_s;
    logic [31:0]  sel_word_s;

    // Sub-line and sub-word address bits are intentionally dropped.
    logic addr_lsb_unused;
    assign addr_lsb_unused = ^{i_addr[3:0], d_addr[1:0]};

    // Data side wins unless an instruction miss has already waited out its allowance.
    assign data_win_s = d_req & (~i_req | (starve_cnt_q < STARVE_LIMIT_C));

    // Load word select uses the latched address, not the live d_addr.
    always_comb begin
        case (mem_addr_q[3:2])
            2'd0:    sel_word_s = mem_rdata[31:0];
            2'd1:    sel_word_s = mem_rdata[63:32];
            2'd2:    sel_word_s = mem_rdata[95:64];
            2'd3:    sel_word_s = mem_rdata[127:96];
            default: sel_word_s = mem_rdata[31:0];
        endcase
    end

    // Starvation counter: counts data grants while an instruction miss waits.
    always_comb begin
        if (!i_req) begin
            starve_cnt_d = 4'd0;
        end else if ((state_q == ST_IDLE) && !data_win_s) begin
            starve_cnt_d = 4'd0;
        end else if ((state_q == ST_IDLE) && (starve_cnt_q != 4'hF)) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end else begin
            starve_cnt_d = starve_cnt_q;
        end
    end

    // Sequencer next state and next registered outputs.
    always_comb begin
        state_d     = state_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        i_line_d    = i_line_q;
        d_rdata_d   = d_rdata_q;
        i_valid_d   = 1'b0;
        d_valid_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (data_win_s) begin
                    state_d     = ST_D_BUSY;
                    mem_en_d    = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = {d_addr[31:2], 2'b00};
                    mem_wdata_d = d_wdata;
                end else if (i_req) begin
                    state_d    = ST_I_BUSY;
                    mem_en_d   = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = {i_addr[31:4], 4'h0};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_I_BUSY: begin
                if (mem_ready) begin
                    state_d   = ST_RESP;
                    mem_en_d  = 1'b0;
                    i_line_d  = mem_rdata;
                    i_valid_d = 1'b1;
                end else begin
                    state_d = ST_I_BUSY;
                end
            end
            ST_D_BUSY: begin
                if (mem_ready) begin
                    state_d   = ST_RESP;
                    mem_en_d  = 1'b0;
                    mem_we_d  = 1'b0;
                    d_valid_d = 1'b1;
                    // A store leaves the last load word in place.
                    if (!mem_we_q) begin
                        d_rdata_d = sel_word_s;
                    end else begin
                        d_rdata_d = d_rdata_q;
                    end
                end else begin
                    state_d = ST_D_BUSY;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d  = ST_IDLE;
                mem_en_d = 1'b0;
                mem_we_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            starve_cnt_q <= 4'd0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 32'd0;
            mem_wdata_q  <= 32'd0;
            i_line_q     <= 128'd0;
            d_rdata_q    <= 32'd0;
            i_valid_q    <= 1'b0;
            d_valid_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            i_line_q     <= i_line_d;
            d_rdata_q    <= d_rdata_d;
            i_valid_q    <= i_valid_d;
            d_valid_q    <= d_valid_d;
        end
    end

    assign o_pc_hold = i_req & ~i_valid_q;
    assign o_i_line  = i_line_q;
    assign o_i_valid = i_valid_q;
    assign o_d_rdata = d_rdata_q;
    assign o_d_valid = d_valid_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: doc/imem_dmem_arbiter.md
# imem_dmem_arbiter

Sequencer and arbiter that shares the single-port main memory between the instruction-fetch stage and the data-memory stage. On an instruction-cache miss, it fetches the 128-bit line that the fetch stage loads into its cache and holds the PC until the line arrives. It also serves word loads and stores from the data stage. It sits between both pipeline stages and the memory model, owns every memory transaction, and enforces a bounded-starvation priority policy.

## Interface

Parameters:
- STARVE_LIMIT, default 4: maximum consecutive data grants issued while an instruction request is pending; range 1–15.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset, synchronous and active-high.
- i_req  input  1  instruction-cache miss; held high until o_i_valid.
- i_addr  input  32  miss PC; stable while i_req is high.
- o_i_line  output  128  fetched line, registered.
- o_i_valid  output  1  one-cycle pulse; o_i_line is valid in this cycle.
- o_pc_hold  output  1  stall to the fetch stage; drives the PC-update enable low.
- d_req  input  1  data access request; held high until o_d_valid.
- d_we  input  1  1 = store, 0 = load.
- d_addr  input  32  byte address; bits [1:0] are ignored.
- d_wdata  input  32  store data.
- o_d_rdata  output  32  load word, registered.
- o_d_valid  output  1  one-cycle completion pulse for a load or a store.
- mem_en  output  1  memory request; held until mem_ready.
- mem_we  output  1  memory write strobe.
- mem_addr  output  32  memory address.
- mem_wdata  output  32  memory write word.
- mem_rdata  input  128  memory read line; valid while mem_ready is high.
- mem_ready  input  1  memory completion, asserted for one cycle.

## Operation

- FSM states: IDLE, I_BUSY, D_BUSY, RESP.
- **IDLE** arbitration, evaluated each cycle:
  - If d_req is high and (i_req is low, or starve_cnt < STARVE_LIMIT), go to D_BUSY.
  - Otherwise, if i_req is high, go to I_BUSY.
  - The data stage has default priority because it is older in the pipeline.
- **starve_cnt** (4 bits):
  - Increments on each data grant made while i_req is high.
  - Clears on an instruction grant, or whenever i_req is low.
  - Saturates at 15.
- **I_BUSY**:
  - mem_en = 1, mem_we = 0.
  - mem_addr = {i_addr[31:4], 4'b0}, i.e. line-aligned.
  - On mem_ready: capture mem_rdata into o_i_line, go to RESP.
- **D_BUSY**:
  - mem_en = 1, mem_we = d_we.
  - mem_addr = {d_addr[31:2], 2'b0}; mem_wdata = d_wdata.
  - On mem_ready: for a load, o_d_rdata = mem_rdata[32*d_addr[3:2] +: 32]; for a store, o_d_rdata is unchanged. Go to RESP.
- **RESP**: pulse o_i_valid or o_d_valid for the granted requester only, then return to IDLE. RESP always lasts exactly 1 cycle.
- Addresses and write data are sampled at the grant edge into internal registers. mem_addr and mem_wdata come from those registers, so they stay stable even if a requester misbehaves.
- **o_pc_hold** = i_req & ~o_i_valid (combinational). This freezes the PC from the miss cycle through the cycle before the line is delivered.
- **Dropped request:** if a requester deasserts its req mid-transaction, the transaction still completes and the valid pulse is still generated. The requester ignores it.
- **Both requests in RESP:** a new request that arrives while in RESP is not granted until IDLE. There is no back-to-back grant without an IDLE cycle.
- **Reset values:**
  - State = IDLE, starve_cnt = 0.
  - mem_en = mem_we = 0, o_i_valid = o_d_valid = 0.
  - o_i_line = 0, o_d_rdata = 0.
  - mem_addr = mem_wdata = 0.
- **Reset mid-operation:** the state goes to IDLE on that edge and mem_en is low from the next cycle. No valid pulse is generated for the aborted transaction. The memory model must tolerate a dropped request.

## Timing

- Request first seen high in IDLE at edge N → mem_en is high from cycle N+1 (registered outputs).
- mem_ready is sampled high at edge M → the valid pulse is high during cycle M+1 → the FSM is back in IDLE at cycle M+2.
- Minimum request-to-valid latency is 3 cycles, with mem_ready arriving in the first cycle mem_en is high.
- Throughput is at most one transaction per 3 cycles.
- mem_en never drops before mem_ready, and mem_en/mem_we never change during a transaction.
- mem_ready while in IDLE or RESP is ignored.

## Test plan

- **Instruction miss:** i_req with i_addr = 0x0000_0044, memory returns 0xDDDD…_AAAA with 2-cycle latency.
  - mem_addr = 0x0000_0040.
  - o_i_valid pulses once, 4 cycles after the request, with o_i_line = the returned line.
  - o_pc_hold is high for the 3 cycles before the pulse.
- **Data load word select:** d_req, d_we = 0, d_addr = 0x0000_1008, mem_rdata = {W3, W2, W1, W0} → o_d_rdata = W2, o_d_valid pulses once.
- **Store:** d_we = 1, d_addr = 0x0000_2003, d_wdata = 0xCAFE_F00D → mem_we = 1, mem_addr = 0x0000_2000, mem_wdata = 0xCAFE_F00D held until mem_ready; o_d_valid pulses.
- **Simultaneous requests, STARVE_LIMIT = 2:** both i_req and d_req held continuously → grant order D, D, I, D, D, I…; starve_cnt returns to 0 after each I grant.
- **Reset mid-I_BUSY:** assert rst 1 cycle before mem_ready → no o_i_valid; mem_en is low the cycle after reset; all outputs at their reset values.
- **Dropped request:** d_req deasserted during D_BUSY → transaction completes; o_d_valid still pulses once; the FSM returns to IDLE with no further grant.
